// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the programmable synchronous FIFO.
package fifo_pkg;

    typedef enum logic [0:0] {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    localparam int unsigned FIFO_WIDTH_DEF = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // No reset: contents are logically discarded via the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost flags and standard or first-word-fall-through reads.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1,
    parameter fifo_mode_e  MODE       = FIFO_STD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty,
    output logic                          almostfull,
    output logic                          almostempty,
    output logic                          wr_ack,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_prog: FIFO_DEPTH must be a power of two and at least 4");
    end
    if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
        $error("sync_fifo_prog: AE_LEVEL must be below AF_LEVEL");
    end

    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [FIFO_WIDTH-1:0] data_out_q;
    logic [FIFO_WIDTH-1:0] head;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  wr_accept, rd_accept;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign almostfull  = (count_q >= CW'(AF_LEVEL));
    assign almostempty = (count_q <= CW'(AE_LEVEL));

    // A read frees the slot the simultaneous write lands in, so full does not block it.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_accept && !rd_accept) begin
                count_q <= count_q + 1'b1;
            end else if (rd_accept && !wr_accept) begin
                count_q <= count_q - 1'b1;
            end
            // FWFT tracks the visible head so the last shown word persists once empty.
            if (MODE == FIFO_FWFT) begin
                if (!empty) begin
                    data_out_q <= head;
                end
            end else if (rd_accept) begin
                data_out_q <= head;
            end
            wr_ack_q    <= wr_accept;
            overflow_q  <= wr_en && !wr_accept;
            underflow_q <= rd_en && empty;
        end
    end

    assign data_out  = ((MODE == FIFO_FWFT) && !empty) ? head : data_out_q;
    assign count     = count_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: scoreboarded standard-mode instance plus a directed FWFT instance.
module tb_sync_fifo_prog;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        wr_en, rd_en;
    logic [15:0] data_out;
    logic [3:0]  count;
    logic        full, empty, almostfull, almostempty, wr_ack, overflow, underflow;

    logic [15:0] f_data_in;
    logic        f_wr_en, f_rd_en;
    logic [15:0] f_data_out;
    logic [3:0]  f_count;
    logic        f_full, f_empty, f_af, f_ae, f_wr_ack, f_ovf, f_udf;

    int tests = 0;
    int fails = 0;

    logic [15:0] model_q[$];
    logic [15:0] exp_q[$];
    logic        tb_rd_fire = 1'b0;
    logic        out_due    = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_prog #(
        .MODE (FIFO_STD)
    ) u_std (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    sync_fifo_prog #(
        .MODE (FIFO_FWFT)
    ) u_fwft (
        .clk         (clk),
        .rst         (rst),
        .data_in     (f_data_in),
        .wr_en       (f_wr_en),
        .rd_en       (f_rd_en),
        .data_out    (f_data_out),
        .count       (f_count),
        .full        (f_full),
        .empty       (f_empty),
        .almostfull  (f_af),
        .almostempty (f_ae),
        .wr_ack      (f_wr_ack),
        .overflow    (f_ovf),
        .underflow   (f_udf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a standard-mode read presents its word one edge after acceptance.
    always @(posedge clk) out_due <= tb_rd_fire && !rst;

    always @(negedge clk) begin
        if (out_due) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL data_out: got %0h expected nothing (scoreboard empty)", data_out);
            end else begin
                check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cycle(input logic w, input logic [15:0] d, input logic r);
        logic rd_acc, wr_acc;
        int   sz;
        sz       = model_q.size();
        rd_acc   = r && (sz != 0);
        wr_acc   = w && ((sz != 8) || rd_acc);
        data_in  = d;
        wr_en    = w;
        rd_en    = r;
        tb_rd_fire = rd_acc;
        if (rd_acc) exp_q.push_back(model_q.pop_front());
        if (wr_acc) model_q.push_back(d);
        @(posedge clk);
        #1;
        sz = model_q.size();
        check("count", 32'(count), 32'(sz));
        check("full", 32'(full), 32'(sz == 8));
        check("empty", 32'(empty), 32'(sz == 0));
        check("almostfull", 32'(almostfull), 32'(sz >= 7));
        check("almostempty", 32'(almostempty), 32'(sz <= 1));
        check("wr_ack", 32'(wr_ack), 32'(wr_acc));
        check("overflow", 32'(overflow), 32'(w && !wr_acc));
        check("underflow", 32'(underflow), 32'(r && !rd_acc));
        wr_en = 1'b0;
        rd_en = 1'b0;
        tb_rd_fire = 1'b0;
    endtask

    task automatic do_reset(input logic w);
        rst   = 1'b1;
        wr_en = w;
        rd_en = 1'b0;
        data_in = 16'hdead;
        model_q.delete();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_almostempty", 32'(almostempty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_almostfull", 32'(almostfull), 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
    endtask

    task automatic fcycle(input logic w, input logic [15:0] d, input logic r);
        f_data_in = d;
        f_wr_en   = w;
        f_rd_en   = r;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0;
        f_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_data_in = '0;
        @(posedge clk);
        do_reset(1'b0);

        // Fill 0x0001..0x0008, then overflow attempt.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b0);
        check("full_after_8", 32'(full), 32'd1);
        check("count_after_8", 32'(count), 32'd8);
        cycle(1'b1, 16'haaaa, 1'b0);
        check("overflow_full", 32'(overflow), 32'd1);
        cycle(1'b0, 16'h0, 1'b0);
        check("overflow_one_cycle", 32'(overflow), 32'd0);

        for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0);
        check("empty_after_drain", 32'(empty), 32'd1);

        // Underflow, then simultaneous write/read while empty.
        cycle(1'b0, 16'h0, 1'b1);
        check("underflow_empty", 32'(underflow), 32'd1);
        cycle(1'b1, 16'h00c3, 1'b1);
        check("wr_rd_empty_count", 32'(count), 32'd1);
        cycle(1'b0, 16'h0, 1'b1);

        // Full with continuous write+read across pointer wraps.
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 16'h0200 + 16'(i), 1'b1);
        check("count_steady_full", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0);

        // Reset at count=5 with a concurrent write.
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0300 + 16'(i), 1'b0);
        check("count_before_rst", 32'(count), 32'd5);
        do_reset(1'b1);

        // FWFT: head appears as soon as empty falls, and persists after the pop empties it.
        check("fwft_rst_data", 32'(f_data_out), 32'd0);
        fcycle(1'b1, 16'h1234, 1'b0);
        check("fwft_empty_fall", 32'(f_empty), 32'd0);
        check("fwft_head", 32'(f_data_out), 32'h1234);
        fcycle(1'b0, 16'h0, 1'b1);
        check("fwft_empty_again", 32'(f_empty), 32'd1);
        check("fwft_hold", 32'(f_data_out), 32'h1234);
        fcycle(1'b1, 16'h5678, 1'b0);
        fcycle(1'b1, 16'h9abc, 1'b0);
        check("fwft_head_order", 32'(f_data_out), 32'h5678);
        fcycle(1'b0, 16'h0, 1'b1);
        check("fwft_next_head", 32'(f_data_out), 32'h9abc);
        check("fwft_count", 32'(f_count), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- FIFO_WIDTH, 16, data width in bits.
- FIFO_DEPTH, 8, number of entries; power of two, at least 4.
- AF_LEVEL, FIFO_DEPTH-1, almostfull threshold.
- AE_LEVEL, 1, almostempty threshold.
- MODE, FIFO_STD, read mode: FIFO_STD or FIFO_FWFT.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- data_in, in, FIFO_WIDTH, write data.
- wr_en, in, 1, write request.
- rd_en, in, 1, read request.
- data_out, out, FIFO_WIDTH, read data.
- count, out, $clog2(FIFO_DEPTH)+1, current occupancy.
- full / empty, out, 1, occupancy is FIFO_DEPTH / occupancy is 0.
- almostfull / almostempty, out, 1, threshold flags.
- wr_ack, out, 1, previous-cycle write was accepted.
- overflow / underflow, out, 1, previous-cycle write / read was rejected.

Function
REQ-003 Write acceptance SHALL be wr_en && (!full || rd_accept), sampled on the rising edge of clk.
REQ-004 Read acceptance (rd_accept) SHALL be rd_en && !empty.
REQ-005 The write pointer SHALL advance by 1 on each accepted write, wrapping from FIFO_DEPTH-1 to 0.
REQ-006 The read pointer SHALL advance by 1 on each accepted read, wrapping from FIFO_DEPTH-1 to 0.
REQ-007 count SHALL be a register updated each edge: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-008 full, empty, almostfull and almostempty SHALL be combinational decodes of registered count, so they change in the cycle after the causing edge.
REQ-009 almostfull SHALL be count >= AF_LEVEL; almostempty SHALL be count <= AE_LEVEL.
REQ-010 wr_ack SHALL be registered: 1 for exactly one cycle after each accepted write, else 0.
REQ-011 overflow SHALL be registered: 1 for one cycle after wr_en was high and the write was not accepted.
REQ-012 underflow SHALL be registered: 1 for one cycle after rd_en was high while empty.
REQ-013 FIFO_STD: data_out SHALL be registered, load the head entry on an accepted read (one-cycle latency), and otherwise hold.
REQ-014 FIFO_FWFT: data_out SHALL show the head entry combinationally whenever !empty, with rd_en acting as pop.
REQ-015 FIFO_FWFT: data_out SHALL hold its last value while empty.
REQ-016 Full with wr_en and rd_en both high: both SHALL be accepted, count unchanged, overflow=0.
REQ-017 Empty with wr_en and rd_en both high: only the write SHALL be accepted, count becomes 1, underflow=1.
REQ-018 Data SHALL be returned in strict write order across any number of pointer wraps.
REQ-019 Elaboration SHALL fail if FIFO_DEPTH is not a power of two, or if AE_LEVEL >= AF_LEVEL.

Reset
REQ-020 While rst=1 at an edge, the block SHALL clear both pointers and set count=0, data_out=0, wr_ack=0, overflow=0, underflow=0.
REQ-021 After reset, combinational flags SHALL read empty=1, almostempty=1, full=0, almostfull=0.
REQ-022 Reset SHALL take priority over any simultaneous wr_en or rd_en.
REQ-023 Reset SHALL discard stored contents logically; the storage array need not be cleared.

Structure
REQ-024 Package fifo_pkg SHALL hold the fifo_mode_e enum (FIFO_STD, FIFO_FWFT) and default FIFO_WIDTH and FIFO_DEPTH constants.
REQ-025 Storage SHALL be one sub-module, fifo_mem, containing a FIFO_DEPTH x FIFO_WIDTH array with a synchronous write port and an asynchronous read port.
REQ-026 Pointer, count and flag logic SHALL reside in sync_fifo_prog.

Verification
REQ-027 Use defaults (16x8) with MODE=FIFO_STD for REQ-028 to REQ-030.
REQ-028 Reset, then write 0x0001..0x0008 on 8 consecutive cycles -> wr_ack=1 each following cycle; full=1 and count=8 after the 8th write; almostfull=1 from count=7.
REQ-029 Write 0xAAAA while full -> overflow=1 for one cycle, count stays 8; then 8 reads -> data_out 0x0001..0x0008, each one cycle after its read; empty=1 afterwards.
REQ-030 rd_en while empty -> underflow=1 for one cycle; wr_en and rd_en together while empty -> count=1, underflow=1.
REQ-031 Fill to 8, then hold wr_en=rd_en=1 for 20 cycles with incrementing data -> count stays 8, no overflow, output order intact across wraps.
REQ-032 MODE=FIFO_FWFT: write 0x1234 into an empty FIFO -> data_out=0x1234 in the cycle empty falls, with no rd_en.
REQ-033 Assert rst at count=5 with wr_en=1 -> next cycle count=0, empty=1, wr_ack=0.
